prbs_checker: RTL and testbench

Receive-side PRBS21 checker at the far end of the AFE signal chain. Each emulated UI (`clk_en`), it slices the final real-valued equalizer/nonlinearity output to a bit and self-synchronizes to the transmitter's PRBS21 sequence (b[n] = b[n-21] ^ b[n-2]). It then counts checked bits and bit errors, so emulation runs can report BER through the chain.

---
 rtl/prbs_pkg.sv | 23 ++
 rtl/prbs_window_mon.sv | 44 ++++
 rtl/prbs_checker.sv | 132 +++++++++++++
 tb/tb_prbs_checker.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS21 definitions used by both the TX-side generator and the RX-side checker.
package prbs_pkg;

  localparam int PRBS_LEN = 21;
  localparam int TAP_HI   = 20;
  localparam int TAP_LO   = 1;

  typedef enum logic {
    SEED  = 1'b0,
    CHECK = 1'b1
  } prbs_state_t;

  // Next PRBS21 bit from a history whose bit 0 is the newest bit.
  function automatic logic prbs21_bit(input logic [PRBS_LEN-1:0] hist);
    return hist[TAP_HI] ^ hist[TAP_LO];
  endfunction

  // Advance a PRBS21 history by one bit (newest bit enters at bit 0).
  function automatic logic [PRBS_LEN-1:0] prbs21_next(input logic [PRBS_LEN-1:0] hist);
    return {hist[PRBS_LEN-2:0], prbs21_bit(hist)};
  endfunction

endpackage

// File: rtl/prbs_window_mon.sv
// Lock monitor: counts errors over fixed windows of checked bits and flags loss of lock
// on the bit that brings the window's error count up to the threshold.
module prbs_window_mon #(
  parameter int WIN        = 64,
  parameter int ERR_THRESH = 8
) (
  input  logic emu_clk,
  input  logic emu_rst,
  input  logic bit_en,
  input  logic bit_err,
  output logic loss
);

  localparam int CNT_W  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int ERR_CW = $clog2(ERR_THRESH + 1);

  localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WIN - 1);
  localparam logic [ERR_CW-1:0] THRESH_M1 = ERR_CW'(ERR_THRESH - 1);

  logic [CNT_W-1:0]  win_cnt;
  logic [ERR_CW-1:0] win_err;

  // Loss is decided combinationally so the checker can drop lock on this very bit.
  always_comb begin
    loss = bit_en && bit_err && (win_err == THRESH_M1);
  end

  // Window position and error tally; a loss starts a fresh window for the next lock attempt.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (bit_en) begin
      if (loss || (win_cnt == WIN_LAST)) begin
        win_cnt <= '0;
        win_err <= '0;
      end else begin
        win_cnt <= win_cnt + CNT_W'(1);
        win_err <= win_err + ERR_CW'(bit_err);
      end
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS21 checker: slices the real-valued chain output, self-synchronizes to
// the transmitted sequence, and counts checked bits and bit errors for BER reporting.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int IN_WIDTH    = 18,
  parameter int IN_EXPONENT = -12,
  parameter bit INVERT      = 1'b0,
  parameter int WIN         = 64,
  parameter int ERR_THRESH  = 8,
  parameter int BIT_W       = 48,
  parameter int ERR_W       = 32
) (
  input  logic                       emu_clk,
  input  logic                       emu_rst,
  input  logic                       clk_en,
  input  logic signed [IN_WIDTH-1:0] in_,
  input  logic                       clear,
  output logic                       locked,
  output logic                       err_pulse,
  output logic [BIT_W-1:0]           bit_count,
  output logic [ERR_W-1:0]           err_count
);

  // Decision threshold is 0.0; converting through the exponent keeps it in the input's fixed-point units.
  localparam real SLICE_LEVEL = 0.0;
  localparam logic signed [IN_WIDTH-1:0] SLICE_CODE =
    IN_WIDTH'($rtoi(SLICE_LEVEL * (2.0 ** (-IN_EXPONENT))));

  localparam int SEED_W = $clog2(PRBS_LEN);
  localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(PRBS_LEN - 1);

  prbs_state_t         state;
  prbs_state_t         state_next;
  logic [PRBS_LEN-1:0] hist;
  logic [PRBS_LEN-1:0] hist_next;
  logic [SEED_W-1:0]   seed_cnt;
  logic                d;
  logic                p;
  logic                bit_err;
  logic                check_bit;
  logic                seed_done;
  logic                loss;

  // Slice, predict from pre-shift history, and qualify the accepted bit by state.
  always_comb begin
    d         = (in_ >= SLICE_CODE) ^ INVERT;
    p         = prbs21_bit(hist);
    bit_err   = (d != p);
    hist_next = {hist[PRBS_LEN-2:0], d};
    check_bit = clk_en && (state == CHECK);
    seed_done = clk_en && (state == SEED) && (seed_cnt == SEED_LAST);
  end

  prbs_window_mon #(
    .WIN        (WIN),
    .ERR_THRESH (ERR_THRESH)
  ) u_window_mon (
    .emu_clk (emu_clk),
    .emu_rst (emu_rst),
    .bit_en  (check_bit),
    .bit_err (bit_err),
    .loss    (loss)
  );

  // State register.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state <= SEED;
    end else begin
      state <= state_next;
    end
  end

  // Seeding locks only onto a nonzero history; too many window errors force a re-seed.
  always_comb begin
    state_next = state;
    case (state)
      SEED:    if (seed_done && (hist_next != '0)) state_next = CHECK;
      CHECK:   if (loss) state_next = SEED;
      default: state_next = SEED;
    endcase
  end

  // Lock indication follows the state directly.
  always_comb begin
    locked = (state == CHECK);
  end

  // History shifts on every accepted bit in every state, which is what makes the checker self-synchronizing.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      hist <= '0;
    end else if (clk_en) begin
      hist <= hist_next;
    end
  end

  // Seed counter spans 21 bits; it wraps to 0 whether or not lock is acquired.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      seed_cnt <= '0;
    end else if (clk_en && (state == SEED)) begin
      seed_cnt <= (seed_cnt == SEED_LAST) ? '0 : seed_cnt + SEED_W'(1);
    end
  end

  // Error pulse lasts one emu_clk cycle because it is recomputed every cycle.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= check_bit && bit_err;
    end
  end

  // Saturating bit/error counters; clear beats a same-cycle increment.
  always_ff @(posedge emu_clk) begin
    if (emu_rst || clear) begin
      bit_count <= '0;
      err_count <= '0;
    end else if (check_bit) begin
      if (bit_count != '1) begin
        bit_count <= bit_count + BIT_W'(1);
      end
      if (bit_err && (err_count != '1)) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a driver feeds PRBS21 streams and pushes the expected
// error/lock events; a monitor pops and compares them whenever the DUT shows one.
module tb_prbs_checker;

  localparam int IN_W = 18;

  localparam logic signed [IN_W-1:0] P_ONE  = 18'sd4096;
  localparam logic signed [IN_W-1:0] M_ONE  = -18'sd4096;
  localparam logic signed [IN_W-1:0] M_HALF = -18'sd2048;
  localparam logic signed [IN_W-1:0] ZERO   = 18'sd0;
  localparam logic signed [IN_W-1:0] M_LSB  = -18'sd1;

  localparam int EV_ERR  = 0;
  localparam int EV_RISE = 1;
  localparam int EV_FALL = 2;

  typedef struct {
    int kind;
    int ui;
  } ev_t;

  logic                   emu_clk = 1'b0;
  logic                   emu_rst = 1'b0;
  logic                   clk_en  = 1'b0;
  logic                   clear   = 1'b0;
  logic signed [IN_W-1:0] in_     = '0;

  logic        locked;
  logic        err_pulse;
  logic [47:0] bit_count;
  logic [31:0] err_count;

  logic        locked_inv;
  logic        err_pulse_inv;
  logic [47:0] bit_count_inv;
  logic [31:0] err_count_inv;

  logic        locked_sat;
  logic        err_pulse_sat;
  logic [7:0]  bit_count_sat;
  logic [31:0] err_count_sat;

  int          checks = 0;
  int          errors = 0;
  int          ui     = 0;
  bit          mon_en = 1'b0;
  logic        prev_locked = 1'b0;
  logic [20:0] gen = '1;
  ev_t         exp_q[$];

  always #5 emu_clk = ~emu_clk;

  prbs_checker dut (
    .emu_clk   (emu_clk),
    .emu_rst   (emu_rst),
    .clk_en    (clk_en),
    .in_       (in_),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .bit_count (bit_count),
    .err_count (err_count)
  );

  prbs_checker #(.INVERT(1'b1)) dut_inv (
    .emu_clk   (emu_clk),
    .emu_rst   (emu_rst),
    .clk_en    (clk_en),
    .in_       (in_),
    .clear     (clear),
    .locked    (locked_inv),
    .err_pulse (err_pulse_inv),
    .bit_count (bit_count_inv),
    .err_count (err_count_inv)
  );

  prbs_checker #(.BIT_W(8)) dut_sat (
    .emu_clk   (emu_clk),
    .emu_rst   (emu_rst),
    .clk_en    (clk_en),
    .in_       (in_),
    .clear     (clear),
    .locked    (locked_sat),
    .err_pulse (err_pulse_sat),
    .bit_count (bit_count_sat),
    .err_count (err_count_sat)
  );

  function automatic string ev_name(input int kind);
    case (kind)
      EV_ERR:  return "err";
      EV_RISE: return "lock_rise";
      default: return "lock_fall";
    endcase
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic observe(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL sb_unexpected got %s at ui=%0d, expected no event", ev_name(kind), ui);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind != kind) || (e.ui != ui)) begin
        errors++;
        $display("[TB] FAIL sb_event got %s at ui=%0d, expected %s at ui=%0d",
                 ev_name(kind), ui, ev_name(e.kind), e.ui);
      end
    end
  endtask

  task automatic push_event(input int kind, input int at_ui);
    ev_t e;
    e.kind = kind;
    e.ui   = at_ui;
    exp_q.push_back(e);
  endtask

  // Independent TX-side PRBS21 generator: b[n] = b[n-21] ^ b[n-2].
  task automatic next_prbs_bit(output logic b);
    b   = gen[20] ^ gen[1];
    gen = {gen[19:0], b};
  endtask

  task automatic applyStimulus(input logic signed [IN_W-1:0] val, input int gap, input bit clr);
    @(negedge emu_clk);
    in_    = val;
    clk_en = 1'b1;
    clear  = clr;
    @(posedge emu_clk);
    ui = ui + 1;
    for (int i = 1; i < gap; i++) begin
      @(negedge emu_clk);
      clk_en = 1'b0;
      clear  = 1'b0;
      @(posedge emu_clk);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge emu_clk);
      clk_en = 1'b0;
      clear  = 1'b0;
    end
  endtask

  // Reset is held with clk_en and clear high to show that reset overrides both.
  task automatic do_reset(input bit was_locked, input string tag);
    @(negedge emu_clk);
    emu_rst = 1'b1;
    clk_en  = 1'b1;
    clear   = 1'b1;
    in_     = P_ONE;
    ui      = 0;
    if (was_locked) push_event(EV_FALL, 0);
    @(negedge emu_clk);
    emu_rst = 1'b0;
    clk_en  = 1'b0;
    clear   = 1'b0;
    checkOutput({tag, "_rst_locked"}, locked, 0);
    checkOutput({tag, "_rst_err_pulse"}, err_pulse, 0);
    checkOutput({tag, "_rst_bit_count"}, bit_count, 0);
    checkOutput({tag, "_rst_err_count"}, err_count, 0);
  endtask

  // Monitor: turns DUT output activity into events and compares each against the scoreboard.
  always @(negedge emu_clk) begin
    if (mon_en) begin
      if (err_pulse === 1'b1) observe(EV_ERR);
      if (locked !== prev_locked) observe((locked === 1'b1) ? EV_RISE : EV_FALL);
      prev_locked = locked;
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic b;

    // Clean stream, clk_en every 4th cycle.
    do_reset(1'b0, "init");
    mon_en = 1'b1;
    gen = '1;
    push_event(EV_RISE, 21);
    for (int u = 1; u <= 10000; u++) begin
      next_prbs_bit(b);
      applyStimulus(b ? P_ONE : M_ONE, 4, 1'b0);
    end
    idle(2);
    checkOutput("clean_locked", locked, 1);
    checkOutput("clean_bit_count", bit_count, 9979);
    checkOutput("clean_err_count", err_count, 0);
    checkOutput("sat_bit_count", bit_count_sat, 255);
    checkOutput("sat_err_count", err_count_sat, 0);
    checkOutput("sat_locked", locked_sat, 1);
    checkOutput("clean_sb_drain", exp_q.size(), 0);

    // Single flipped UI at 500, full-rate clk_en.
    do_reset(1'b1, "flip");
    gen = '1;
    push_event(EV_RISE, 21);
    push_event(EV_ERR, 500);
    push_event(EV_ERR, 502);
    push_event(EV_ERR, 521);
    for (int u = 1; u <= 600; u++) begin
      next_prbs_bit(b);
      if (u == 500) b = ~b;
      applyStimulus(b ? P_ONE : M_ONE, 1, 1'b0);
    end
    idle(2);
    checkOutput("flip_locked", locked, 1);
    checkOutput("flip_err_count", err_count, 3);
    checkOutput("flip_bit_count", bit_count, 579);
    checkOutput("flip_sb_drain", exp_q.size(), 0);

    // Inverted stream: every checked bit errors, lock drops after 8 and re-seeds.
    do_reset(1'b1, "inv");
    gen = '1;
    push_event(EV_RISE, 21);
    for (int k = 0; k < 3; k++) begin
      for (int e = 1; e <= 8; e++) push_event(EV_ERR, 21 + 29 * k + e);
      push_event(EV_FALL, 29 + 29 * k);
      if (k < 2) push_event(EV_RISE, 50 + 29 * k);
    end
    for (int u = 1; u <= 100; u++) begin
      next_prbs_bit(b);
      applyStimulus(b ? M_ONE : P_ONE, 1, 1'b0);
    end
    idle(2);
    checkOutput("inv_locked", locked, 0);
    checkOutput("inv_err_count", err_count, 24);
    checkOutput("inv_bit_count", bit_count, 24);
    checkOutput("invp_locked", locked_inv, 1);
    checkOutput("invp_err_count", err_count_inv, 0);
    checkOutput("invp_bit_count", bit_count_inv, 79);
    checkOutput("invp_err_pulse", err_pulse_inv, 0);
    checkOutput("inv_sb_drain", exp_q.size(), 0);

    // Constant negative input never locks.
    do_reset(1'b0, "dead");
    for (int u = 1; u <= 200; u++) begin
      applyStimulus(M_HALF, 2, 1'b0);
    end
    idle(2);
    checkOutput("dead_locked", locked, 0);
    checkOutput("dead_bit_count", bit_count, 0);
    checkOutput("dead_err_count", err_count, 0);
    checkOutput("dead_sat_err_pulse", err_pulse_sat, 0);
    checkOutput("dead_sb_drain", exp_q.size(), 0);

    // Slicer boundary (0.0 and -1 LSB) plus reset in the middle of CHECK.
    do_reset(1'b0, "midrst");
    gen = '1;
    push_event(EV_RISE, 21);
    for (int u = 1; u <= 60; u++) begin
      next_prbs_bit(b);
      applyStimulus(b ? ZERO : M_LSB, 1, 1'b0);
    end
    idle(1);
    checkOutput("edge_bit_count", bit_count, 39);
    checkOutput("edge_err_count", err_count, 0);
    do_reset(1'b1, "midrst2");
    push_event(EV_RISE, 21);
    for (int u = 1; u <= 50; u++) begin
      next_prbs_bit(b);
      applyStimulus(b ? P_ONE : M_ONE, 1, 1'b0);
    end
    idle(2);
    checkOutput("relock_locked", locked, 1);
    checkOutput("relock_bit_count", bit_count, 29);
    checkOutput("relock_err_count", err_count, 0);
    checkOutput("relock_sb_drain", exp_q.size(), 0);

    // Clear on the same edge as an error.
    do_reset(1'b1, "clr");
    gen = '1;
    push_event(EV_RISE, 21);
    push_event(EV_ERR, 40);
    push_event(EV_ERR, 42);
    push_event(EV_ERR, 61);
    for (int u = 1; u <= 80; u++) begin
      next_prbs_bit(b);
      if (u == 40) b = ~b;
      applyStimulus(b ? P_ONE : M_ONE, 2, (u == 42));
      if (u == 42) begin
        #1;
        checkOutput("clr_bit_count", bit_count, 0);
        checkOutput("clr_err_count", err_count, 0);
      end
      if (u == 43) begin
        #1;
        checkOutput("clr_resume_bit_count", bit_count, 1);
      end
    end
    idle(2);
    checkOutput("clr_end_bit_count", bit_count, 38);
    checkOutput("clr_end_err_count", err_count, 1);
    checkOutput("clr_end_locked", locked, 1);
    checkOutput("clr_sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
